ssd1306_spi4_sink: RTL and testbench

Synthesizable SSD1306-style 4-wire SPI receiver that sits on the display bus driven by the TinyQV peripheral harness (cs/sdi/sck/dc on uio_out[3:1] and uio_out[4]). It oversamples the SPI lines with the system clock and deframes MSB-first bytes. Command bytes are decoded into addressing and display state. Data bytes are written into a 128x8-page GDDRAM that the bench can read back to check rendered waveforms.

---
 rtl/ssd1306_pkg.sv | 47 ++++
 rtl/ssd1306_spi4_sink_spi4_deframer.sv | 82 ++++++++
 rtl/ssd1306_spi4_sink.sv | 166 ++++++++++++++++
 tb/tb_ssd1306_spi4_sink.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared constants, encodings and helpers for the SSD1306-style 4-wire SPI sink.
// Geometry widths, addressing modes, opcodes and the command-argument FSM states.
package ssd1306_pkg;

  localparam int COLS    = 128;
  localparam int PAGES   = 8;
  localparam int COL_W   = $clog2(COLS);
  localparam int PAGE_W  = $clog2(PAGES);
  localparam int ADDR_W  = COL_W + PAGE_W;

  typedef enum logic [1:0] {
    MODE_HORZ = 2'b00,
    MODE_VERT = 2'b01,
    MODE_PAGE = 2'b10
  } addr_mode_e;

  // Which argument the command decoder expects next
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONTRAST,
    ST_MODE,
    ST_COL_START,
    ST_COL_END,
    ST_PAGE_START,
    ST_PAGE_END,
    ST_SKIP
  } cmd_state_e;

  localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_PAGE_BASE   = 8'hB0;

  // The reserved encoding 2'b11 behaves as page mode
  function automatic addr_mode_e decode_mode(input logic [1:0] arg);
    case (arg)
      2'b00:   decode_mode = MODE_HORZ;
      2'b01:   decode_mode = MODE_VERT;
      default: decode_mode = MODE_PAGE;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi4_sink_spi4_deframer.sv
// Oversampling SPI byte deframer: synchronizes cs/sdi/sck/dc to clk, detects sck
// rising edges and assembles MSB-first bytes, emitting a one-cycle byte_valid pulse.
module spi4_deframer
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_in,
  input  logic       sdi_i,
  input  logic       sck_i,
  input  logic       dc_i,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data
);

  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] dc_sync_reg;
  logic                   sck_prev_reg;
  logic [6:0]             shift_reg;
  logic [2:0]             bit_cnt_reg;
  logic                   byte_valid_reg;
  logic [7:0]             byte_data_reg;
  logic                   byte_is_data_reg;

  logic cs_s, sdi_s, sck_s, dc_s, sck_rise;

  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_reg[SYNC_STAGES-1];
  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign dc_s     = dc_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_reg;

  // cs resets to its idle (deselected) level so no byte starts during reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_reg  <= '1;
      sdi_sync_reg <= '0;
      sck_sync_reg <= '0;
      dc_sync_reg  <= '0;
      sck_prev_reg <= 1'b0;
    end else begin
      cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], cs_in};
      sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi_i};
      sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck_i};
      dc_sync_reg  <= {dc_sync_reg[SYNC_STAGES-2:0], dc_i};
      sck_prev_reg <= sck_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg        <= '0;
      bit_cnt_reg      <= '0;
      byte_valid_reg   <= 1'b0;
      byte_data_reg    <= '0;
      byte_is_data_reg <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      if (cs_s) begin
        bit_cnt_reg <= '0;
      end else if (sck_rise) begin
        shift_reg   <= {shift_reg[5:0], sdi_s};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          byte_data_reg    <= {shift_reg, sdi_s};
          byte_is_data_reg <= dc_s;
          byte_valid_reg   <= 1'b1;
        end
      end
    end
  end

  assign byte_valid   = byte_valid_reg;
  assign byte_data    = byte_data_reg;
  assign byte_is_data = byte_is_data_reg;

endmodule

// File: rtl/ssd1306_spi4_sink.sv
// SSD1306-style 4-wire SPI sink: command decoder, addressing pointers and a
// 128x8-page GDDRAM with a synchronous read port for rendered-image checks.
module ssd1306_spi4_sink
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_in,
  input  logic              sdi_i,
  input  logic              sck_i,
  input  logic              dc_i,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              byte_is_data,
  output logic              display_on,
  output logic [7:0]        contrast,
  output logic [1:0]        addr_mode,
  output logic [COL_W-1:0]  col_ptr,
  output logic [PAGE_W-1:0] page_ptr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  cmd_state_e        state_reg, state_next;
  logic              display_on_reg, display_on_next;
  logic [7:0]        contrast_reg, contrast_next;
  addr_mode_e        mode_reg, mode_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [PAGE_W-1:0] page_reg, page_next;
  logic [COL_W-1:0]  col_start_reg, col_start_next;
  logic [COL_W-1:0]  col_end_reg, col_end_next;
  logic [PAGE_W-1:0] page_start_reg, page_start_next;
  logic [PAGE_W-1:0] page_end_reg, page_end_next;

  logic [7:0] gddram [COLS*PAGES];
  logic [7:0] rd_data_reg;

  spi4_deframer #(.SYNC_STAGES(SYNC_STAGES)) u_deframer (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_in        (cs_in),
    .sdi_i        (sdi_i),
    .sck_i        (sck_i),
    .dc_i         (dc_i),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      display_on_reg <= 1'b0;
      contrast_reg   <= 8'h7F;
      mode_reg       <= MODE_PAGE;
      col_reg        <= '0;
      page_reg       <= '0;
      col_start_reg  <= '0;
      col_end_reg    <= COL_W'(COLS - 1);
      page_start_reg <= '0;
      page_end_reg   <= PAGE_W'(PAGES - 1);
    end else begin
      state_reg      <= state_next;
      display_on_reg <= display_on_next;
      contrast_reg   <= contrast_next;
      mode_reg       <= mode_next;
      col_reg        <= col_next;
      page_reg       <= page_next;
      col_start_reg  <= col_start_next;
      col_end_reg    <= col_end_next;
      page_start_reg <= page_start_next;
      page_end_reg   <= page_end_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    display_on_next = display_on_reg;
    contrast_next   = contrast_reg;
    mode_next       = mode_reg;
    col_next        = col_reg;
    page_next       = page_reg;
    col_start_next  = col_start_reg;
    col_end_next    = col_end_reg;
    page_start_next = page_start_reg;
    page_end_next   = page_end_reg;
    if (byte_valid && byte_is_data) begin
      state_next = ST_IDLE;
      case (mode_reg)
        MODE_HORZ: begin
          if (col_reg == col_end_reg) begin
            col_next  = col_start_reg;
            page_next = (page_reg == page_end_reg) ? page_start_reg : page_reg + 1'b1;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
        MODE_VERT: begin
          if (page_reg == page_end_reg) begin
            page_next = page_start_reg;
            col_next  = (col_reg == col_end_reg) ? col_start_reg : col_reg + 1'b1;
          end else begin
            page_next = page_reg + 1'b1;
          end
        end
        default: begin
          // Page mode wraps at the physical last column, not at col_end
          col_next = (col_reg == COL_W'(COLS - 1)) ? col_start_reg : col_reg + 1'b1;
        end
      endcase
    end else if (byte_valid) begin
      state_next = ST_IDLE;
      case (state_reg)
        ST_CONTRAST:  contrast_next = byte_data;
        ST_MODE:      mode_next = decode_mode(byte_data[1:0]);
        ST_COL_START: begin
          col_start_next = byte_data[COL_W-1:0];
          col_next       = byte_data[COL_W-1:0];
          state_next     = ST_COL_END;
        end
        ST_COL_END:   col_end_next = byte_data[COL_W-1:0];
        ST_PAGE_START: begin
          page_start_next = byte_data[PAGE_W-1:0];
          page_next       = byte_data[PAGE_W-1:0];
          state_next      = ST_PAGE_END;
        end
        ST_PAGE_END:  page_end_next = byte_data[PAGE_W-1:0];
        ST_SKIP:      state_next = ST_IDLE;
        default: begin
          casez (byte_data)
            OP_DISPLAY_OFF: display_on_next = 1'b0;
            OP_DISPLAY_ON:  display_on_next = 1'b1;
            OP_CONTRAST:    state_next = ST_CONTRAST;
            OP_ADDR_MODE:   state_next = ST_MODE;
            OP_COL_ADDR:    state_next = ST_COL_START;
            OP_PAGE_ADDR:   state_next = ST_PAGE_START;
            8'b1011_0???:   page_next = byte_data[PAGE_W-1:0];
            8'b0000_????:   col_next = {col_reg[6:4], byte_data[3:0]};
            8'b0001_0???:   col_next = {byte_data[2:0], col_reg[3:0]};
            OP_CHARGE_PUMP, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB:
                            state_next = ST_SKIP;
            default:        state_next = ST_IDLE;
          endcase
        end
      endcase
    end
  end

  // Unreset RAM with a registered read port so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (byte_valid && byte_is_data) begin
      gddram[{page_reg, col_reg}] <= byte_data;
    end
    rd_data_reg <= gddram[rd_addr];
  end

  assign display_on = display_on_reg;
  assign contrast   = contrast_reg;
  assign addr_mode  = mode_reg;
  assign col_ptr    = col_reg;
  assign page_ptr   = page_reg;
  assign rd_data    = rd_data_reg;

endmodule

// File: tb/tb_ssd1306_spi4_sink.sv
// Directed bench for ssd1306_spi4_sink: bit-bangs SPI bytes and checks decoded
// state, byte pulses and GDDRAM contents against hand-computed values.
module tb_ssd1306_spi4_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_in = 1'b1;
  logic       sdi_i = 1'b0;
  logic       sck_i = 1'b0;
  logic       dc_i = 1'b0;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       display_on;
  logic [7:0] contrast;
  logic [1:0] addr_mode;
  logic [6:0] col_ptr;
  logic [2:0] page_ptr;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int v0;
  logic [7:0] rd_val;

  always #5 clk = ~clk;

  always @(posedge clk) if (byte_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  ssd1306_spi4_sink dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_in        (cs_in),
    .sdi_i        (sdi_i),
    .sck_i        (sck_i),
    .dc_i         (dc_i),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .display_on   (display_on),
    .contrast     (contrast),
    .addr_mode    (addr_mode),
    .col_ptr      (col_ptr),
    .page_ptr     (page_ptr),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the top n bits of b MSB first; sck phases are 4 clk each
  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    logic [7:0] v;
    v = b;
    dc_i = dc;
    for (int i = 0; i < n; i++) begin
      sdi_i = v[7];
      v = {v[6:0], 1'b0};
      wait_clk(4);
      sck_i = 1'b1;
      wait_clk(4);
      sck_i = 1'b0;
    end
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
  endtask

  task automatic cs_set(input logic v);
    @(negedge clk);
    cs_in = v;
    wait_clk(4);
  endtask

  task automatic read_ram(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_byte_valid"}, 32'(byte_valid), 32'h0);
    check_eq({pfx, "_byte_data"}, 32'(byte_data), 32'h00);
    check_eq({pfx, "_byte_is_data"}, 32'(byte_is_data), 32'h0);
    check_eq({pfx, "_display_on"}, 32'(display_on), 32'h0);
    check_eq({pfx, "_contrast"}, 32'(contrast), 32'h7F);
    check_eq({pfx, "_addr_mode"}, 32'(addr_mode), 32'h2);
    check_eq({pfx, "_col_ptr"}, 32'(col_ptr), 32'h0);
    check_eq({pfx, "_page_ptr"}, 32'(page_ptr), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(5);
    check_reset_state("reset");
    rst_n = 1'b1;
    wait_clk(3);

    // Display on
    cs_set(1'b0);
    v0 = valid_cnt;
    send_byte(8'hAF, 1'b0);
    check_eq("af_valid_count", 32'(valid_cnt - v0), 32'd1);
    check_eq("af_byte_data", 32'(byte_data), 32'hAF);
    check_eq("af_is_data", 32'(byte_is_data), 32'h0);
    check_eq("af_display_on", 32'(display_on), 32'h1);

    // Contrast, then contrast with cs toggled between opcode and argument
    send_byte(8'h81, 1'b0);
    send_byte(8'h20, 1'b0);
    check_eq("contrast_20", 32'(contrast), 32'h20);
    check_eq("contrast_arg_not_cmd", 32'(addr_mode), 32'h2);
    send_byte(8'h81, 1'b0);
    cs_set(1'b1);
    cs_set(1'b0);
    send_byte(8'h3C, 1'b0);
    check_eq("contrast_3c_cs_toggle", 32'(contrast), 32'h3C);

    // Page mode writes
    send_byte(8'hB2, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    check_eq("page_col_ptr", 32'(col_ptr), 32'd7);
    check_eq("page_page_ptr", 32'(page_ptr), 32'd2);
    read_ram(10'd261, rd_val);
    check_eq("page_ram_261", 32'(rd_val), 32'hA5);
    read_ram(10'd262, rd_val);
    check_eq("page_ram_262", 32'(rd_val), 32'h5A);

    // Horizontal mode with column window 126..127, pages 0..1
    send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h21, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    check_eq("horz_addr_mode", 32'(addr_mode), 32'h0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    read_ram(10'd126, rd_val);
    check_eq("horz_ram_126", 32'(rd_val), 32'h11);
    read_ram(10'd127, rd_val);
    check_eq("horz_ram_127", 32'(rd_val), 32'h22);
    read_ram(10'd254, rd_val);
    check_eq("horz_ram_254", 32'(rd_val), 32'h33);
    check_eq("horz_page_ptr", 32'(page_ptr), 32'd1);
    check_eq("horz_col_ptr", 32'(col_ptr), 32'd127);

    // Vertical mode, pages 6..7
    send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h07, 1'b0);
    check_eq("vert_addr_mode", 32'(addr_mode), 32'h1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    read_ram(10'd768, rd_val);
    check_eq("vert_ram_768", 32'(rd_val), 32'hAA);
    read_ram(10'd896, rd_val);
    check_eq("vert_ram_896", 32'(rd_val), 32'hBB);
    read_ram(10'd769, rd_val);
    check_eq("vert_ram_769", 32'(rd_val), 32'hCC);
    check_eq("vert_page_ptr", 32'(page_ptr), 32'd7);
    check_eq("vert_col_ptr", 32'(col_ptr), 32'd1);

    // Partial byte discarded by cs high, then a full data byte
    v0 = valid_cnt;
    send_bits(8'hFF, 5, 1'b1);
    cs_set(1'b1);
    cs_set(1'b0);
    send_byte(8'hF0, 1'b1);
    check_eq("partial_valid_count", 32'(valid_cnt - v0), 32'd1);
    check_eq("partial_byte_data", 32'(byte_data), 32'hF0);
    check_eq("partial_is_data", 32'(byte_is_data), 32'h1);
    read_ram(10'd897, rd_val);
    check_eq("partial_ram_897", 32'(rd_val), 32'hF0);

    // Reset mid-byte
    send_bits(8'hFF, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    wait_clk(2);
    check_reset_state("midbyte_reset");
    rst_n = 1'b1;
    wait_clk(4);
    v0 = valid_cnt;
    send_byte(8'hAF, 1'b0);
    check_eq("post_reset_valid_count", 32'(valid_cnt - v0), 32'd1);
    check_eq("post_reset_byte_data", 32'(byte_data), 32'hAF);
    check_eq("post_reset_display_on", 32'(display_on), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
